// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline status in / stall-control out bundle between the 5-stage core and hazard_stall_ctrl.
// master = pipeline side (drives hazard status), slave = the stall controller.
interface hazard_stall_ctrl_if;
  logic [2:0] Rs_if_id;
  logic       Rs_valid_if_id;
  logic [2:0] Rt_if_id;
  logic       Rt_valid_if_id;
  logic [2:0] Rd_id_ex;
  logic       Rd_valid_id_ex;
  logic       WriteReg_id_ex;
  logic       MemRead_id_ex;
  logic       branch_taken_ex;
  logic       imem_busy;
  logic       dmem_busy;
  logic       halt_id;
  logic       pc_we;
  logic       if_id_we;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_mem_we;
  logic       mem_wb_bubble;
  logic       halted;
  logic [2:0] state;

  modport master (
    output Rs_if_id, Rs_valid_if_id, Rt_if_id, Rt_valid_if_id, Rd_id_ex, Rd_valid_id_ex,
           WriteReg_id_ex, MemRead_id_ex, branch_taken_ex, imem_busy, dmem_busy, halt_id,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble, halted, state
  );

  modport slave (
    input  Rs_if_id, Rs_valid_if_id, Rt_if_id, Rt_valid_if_id, Rd_id_ex, Rd_valid_id_ex,
           WriteReg_id_ex, MemRead_id_ex, branch_taken_ex, imem_busy, dmem_busy, halt_id,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble, halted, state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch / memory-wait / halt stall sequencer for the 5-stage core.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt and flush_cnt outputs.
module hazard_stall_ctrl #(
  parameter int LDUSE_STALL_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    LDUSE = 3'd1,
    DWAIT = 3'd2,
    IWAIT = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [1:0] LU_LOAD = 2'(LDUSE_STALL_CYC - 1);

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic       redirect_pend_reg, redirect_pend_next;
  logic       halted_reg, halted_next;
  logic       lu, run_eval;
  logic       pc_we_c, if_id_we_c, if_id_flush_c, id_ex_bubble_c, ex_mem_we_c, mem_wb_bubble_c;

  assign lu = hz.MemRead_id_ex & hz.WriteReg_id_ex & hz.Rd_valid_id_ex &
              ((hz.Rs_valid_if_id & (hz.Rs_if_id == hz.Rd_id_ex)) |
               (hz.Rt_valid_if_id & (hz.Rt_if_id == hz.Rd_id_ex)));

  always_comb begin
    pc_we_c            = 1'b1;
    if_id_we_c         = 1'b1;
    if_id_flush_c      = 1'b0;
    id_ex_bubble_c     = 1'b0;
    ex_mem_we_c        = 1'b1;
    mem_wb_bubble_c    = 1'b0;
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    redirect_pend_next = redirect_pend_reg;
    halted_next        = halted_reg;
    run_eval           = 1'b0;

    case (state_reg)
      RUN: run_eval = 1'b1;
      LDUSE: begin
        if (hz.dmem_busy) begin
          pc_we_c         = 1'b0;
          if_id_we_c      = 1'b0;
          ex_mem_we_c     = 1'b0;
          mem_wb_bubble_c = 1'b1;
          state_next      = DWAIT;
        end else if (cnt_reg == 2'd0) begin
          run_eval = 1'b1;
        end else begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_bubble_c = 1'b1;
          cnt_next       = cnt_reg - 2'd1;
        end
      end
      DWAIT: begin
        if (hz.dmem_busy) begin
          pc_we_c         = 1'b0;
          if_id_we_c      = 1'b0;
          ex_mem_we_c     = 1'b0;
          mem_wb_bubble_c = 1'b1;
        end else if (cnt_reg != 2'd0) begin
          // A nonzero counter means the wait interrupted a load-use stall: resume it.
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ex_bubble_c = 1'b1;
          cnt_next       = cnt_reg - 2'd1;
          state_next     = LDUSE;
        end else begin
          run_eval = 1'b1;
        end
      end
      IWAIT: begin
        if (hz.imem_busy) begin
          pc_we_c       = 1'b0;
          if_id_we_c    = 1'b0;
          if_id_flush_c = 1'b1;
          if (hz.dmem_busy) begin
            ex_mem_we_c     = 1'b0;
            mem_wb_bubble_c = 1'b1;
          end
          if (hz.branch_taken_ex) begin
            id_ex_bubble_c     = 1'b1;
            redirect_pend_next = 1'b1;
          end
        end else if (redirect_pend_reg) begin
          // The fetch that just returned is wrong-path; drop it and fetch the target.
          if_id_flush_c      = 1'b1;
          redirect_pend_next = 1'b0;
          state_next         = RUN;
        end else begin
          run_eval = 1'b1;
        end
      end
      HALT: begin
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        id_ex_bubble_c = 1'b1;
      end
      default: state_next = RUN;
    endcase

    if (run_eval) begin
      state_next = RUN;
      if (hz.dmem_busy) begin
        pc_we_c         = 1'b0;
        if_id_we_c      = 1'b0;
        ex_mem_we_c     = 1'b0;
        mem_wb_bubble_c = 1'b1;
        state_next      = DWAIT;
      end else if (hz.branch_taken_ex) begin
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
      end else if (lu) begin
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        id_ex_bubble_c = 1'b1;
        cnt_next       = LU_LOAD;
        state_next     = LDUSE;
      end else if (hz.halt_id) begin
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        id_ex_bubble_c = 1'b1;
        halted_next    = 1'b1;
        state_next     = HALT;
      end else if (hz.imem_busy) begin
        pc_we_c       = 1'b0;
        if_id_we_c    = 1'b0;
        if_id_flush_c = 1'b1;
        state_next    = IWAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= RUN;
      cnt_reg           <= 2'd0;
      redirect_pend_reg <= 1'b0;
      halted_reg        <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      redirect_pend_reg <= redirect_pend_next;
      halted_reg        <= halted_next;
    end
  end

  // Reset holds the whole pipe with NOPs in every bubble slot.
  assign hz.pc_we         = rst_n & pc_we_c;
  assign hz.if_id_we      = rst_n & if_id_we_c;
  assign hz.ex_mem_we     = rst_n & ex_mem_we_c;
  assign hz.if_id_flush   = ~rst_n | if_id_flush_c;
  assign hz.id_ex_bubble  = ~rst_n | id_ex_bubble_c;
  assign hz.mem_wb_bubble = ~rst_n | mem_wb_bubble_c;
  assign hz.halted        = halted_reg;
  assign hz.state         = state_reg;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_reg, flush_cnt_reg;
  logic        flush_evt;

  // Only a taken-branch flush asserts flush and bubble together.
  assign flush_evt = if_id_flush_c & id_ex_bubble_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      if (!pc_we_c && state_reg != HALT && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (flush_evt && flush_cnt_reg != 16'hFFFF)
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed vector bench for hazard_stall_ctrl (LDUSE_STALL_CYC=1 and =3 instances).
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if hz1 ();
  hazard_stall_ctrl_if hz3 ();

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

  hazard_stall_ctrl #(.LDUSE_STALL_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hz(hz1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  hazard_stall_ctrl #(.LDUSE_STALL_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hz(hz3)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
  );

  // Output pattern order: {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_bubble}
  localparam logic [5:0] NORM  = 6'b110010;
  localparam logic [5:0] FRZ   = 6'b000001;
  localparam logic [5:0] BRF   = 6'b111110;
  localparam logic [5:0] STL   = 6'b000110;
  localparam logic [5:0] IBZ   = 6'b001010;
  localparam logic [5:0] IBZBR = 6'b001110;
  localparam logic [5:0] REDIR = 6'b111010;
  localparam logic [5:0] RSTO  = 6'b001101;

  // Control order: {Rd_valid, WriteReg, MemRead, branch, imem_busy, dmem_busy, halt}
  localparam logic [6:0] C0 = 7'b0000000;
  localparam logic [6:0] LD = 7'b1110000;
  localparam logic [6:0] BR = 7'b0001000;
  localparam logic [6:0] IB = 7'b0000100;
  localparam logic [6:0] DB = 7'b0000010;
  localparam logic [6:0] HL = 7'b0000001;

  typedef struct {
    string      name;
    logic [2:0] rs;
    logic       rs_v;
    logic [2:0] rt;
    logic       rt_v;
    logic [2:0] rd;
    logic [6:0] ctl;
    logic [5:0] exp_o;
    logic [2:0] exp_st;
    logic       exp_h;
  } vec_t;

  int total_cnt = 0;
  int pass_cnt  = 0;

  function automatic vec_t mk(string n, logic [2:0] rs, logic rs_v, logic [2:0] rt, logic rt_v,
                              logic [2:0] rd, logic [6:0] ctl, logic [5:0] exp_o,
                              logic [2:0] exp_st, logic exp_h);
    vec_t v;
    v.name = n; v.rs = rs; v.rs_v = rs_v; v.rt = rt; v.rt_v = rt_v; v.rd = rd;
    v.ctl = ctl; v.exp_o = exp_o; v.exp_st = exp_st; v.exp_h = exp_h;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz1.Rs_if_id = v.rs;  hz1.Rs_valid_if_id = v.rs_v;
    hz1.Rt_if_id = v.rt;  hz1.Rt_valid_if_id = v.rt_v;
    hz1.Rd_id_ex = v.rd;
    {hz1.Rd_valid_id_ex, hz1.WriteReg_id_ex, hz1.MemRead_id_ex, hz1.branch_taken_ex,
     hz1.imem_busy, hz1.dmem_busy, hz1.halt_id} = v.ctl;
    hz3.Rs_if_id = v.rs;  hz3.Rs_valid_if_id = v.rs_v;
    hz3.Rt_if_id = v.rt;  hz3.Rt_valid_if_id = v.rt_v;
    hz3.Rd_id_ex = v.rd;
    {hz3.Rd_valid_id_ex, hz3.WriteReg_id_ex, hz3.MemRead_id_ex, hz3.branch_taken_ex,
     hz3.imem_busy, hz3.dmem_busy, hz3.halt_id} = v.ctl;
  endtask

  task automatic check(input string name, input bit sel, input logic [5:0] exp_o,
                       input logic [2:0] exp_st, input logic exp_h);
    logic [5:0] o;
    logic [2:0] st;
    logic       h;
    if (sel) begin
      o  = {hz3.pc_we, hz3.if_id_we, hz3.if_id_flush, hz3.id_ex_bubble, hz3.ex_mem_we, hz3.mem_wb_bubble};
      st = hz3.state; h = hz3.halted;
    end else begin
      o  = {hz1.pc_we, hz1.if_id_we, hz1.if_id_flush, hz1.id_ex_bubble, hz1.ex_mem_we, hz1.mem_wb_bubble};
      st = hz1.state; h = hz1.halted;
    end
    total_cnt++;
    if (o === exp_o && st === exp_st && h === exp_h) begin
      pass_cnt++;
      $display("ok   %-14s dut%0d out=%b state=%0d halted=%b", name, sel ? 3 : 1, o, st, h);
    end else begin
      $display("FAIL %-14s dut%0d got out=%b state=%0d halted=%b, expected out=%b state=%0d halted=%b",
               name, sel ? 3 : 1, o, st, h, exp_o, exp_st, exp_h);
    end
  endtask

  task automatic run_table(input vec_t tbl[$], input bit sel);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      check(tbl[i].name, sel, tbl[i].exp_o, tbl[i].exp_st, tbl[i].exp_h);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t t1[$];
    vec_t t3[$];
    vec_t idle;

    idle = mk("idle", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, C0, NORM, 3'd0, 1'b0);

    // LDUSE_STALL_CYC=1 instance: one vector per cycle
    t1.push_back(mk("idle",        3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));
    t1.push_back(mk("alu_no_load", 3'd0, 0, 3'd3, 1, 3'd3, 7'b1100000, NORM, 3'd0, 0));
    t1.push_back(mk("lu_rt3",      3'd0, 0, 3'd3, 1, 3'd3, LD,      STL,   3'd0, 0));
    t1.push_back(mk("lu_release",  3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd1, 0));
    t1.push_back(mk("lu_back_run", 3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));
    t1.push_back(mk("lu_rs_r0",    3'd0, 1, 3'd1, 0, 3'd0, LD,      STL,   3'd0, 0));
    t1.push_back(mk("lu_r0_rel",   3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd1, 0));
    t1.push_back(mk("rs_not_read", 3'd5, 0, 3'd0, 0, 3'd5, LD,      NORM,  3'd0, 0));
    t1.push_back(mk("rd_invalid",  3'd0, 0, 3'd2, 1, 3'd2, 7'b0110000, NORM, 3'd0, 0));
    t1.push_back(mk("no_wr_load",  3'd0, 0, 3'd2, 1, 3'd2, 7'b1010000, NORM, 3'd0, 0));
    t1.push_back(mk("rt_differs",  3'd1, 1, 3'd6, 1, 3'd7, LD,      NORM,  3'd0, 0));
    t1.push_back(mk("br_with_lu",  3'd0, 0, 3'd3, 1, 3'd3, LD | BR, BRF,   3'd0, 0));
    t1.push_back(mk("after_br",    3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));
    t1.push_back(mk("db_br_1",     3'd0, 0, 3'd0, 0, 3'd0, DB | BR, FRZ,   3'd0, 0));
    t1.push_back(mk("db_br_2",     3'd0, 0, 3'd0, 0, 3'd0, DB | BR, FRZ,   3'd2, 0));
    t1.push_back(mk("db_br_3",     3'd0, 0, 3'd0, 0, 3'd0, DB | BR, FRZ,   3'd2, 0));
    t1.push_back(mk("db_br_4",     3'd0, 0, 3'd0, 0, 3'd0, DB | BR, FRZ,   3'd2, 0));
    t1.push_back(mk("dwait_exit",  3'd0, 0, 3'd0, 0, 3'd0, BR,      BRF,   3'd2, 0));
    t1.push_back(mk("after_dwait", 3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));
    t1.push_back(mk("ib_enter",    3'd0, 0, 3'd0, 0, 3'd0, IB,      IBZ,   3'd0, 0));
    t1.push_back(mk("ib_br",       3'd0, 0, 3'd0, 0, 3'd0, IB | BR, IBZBR, 3'd3, 0));
    t1.push_back(mk("ib_redirect", 3'd0, 0, 3'd0, 0, 3'd0, C0,      REDIR, 3'd3, 0));
    t1.push_back(mk("after_ib",    3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));
    t1.push_back(mk("halt_enter",  3'd0, 0, 3'd0, 0, 3'd0, HL,      STL,   3'd0, 0));
    t1.push_back(mk("halt_hold",   3'd0, 0, 3'd0, 0, 3'd0, C0,      STL,   3'd4, 1));
    t1.push_back(mk("halt_br",     3'd0, 0, 3'd0, 0, 3'd0, BR,      STL,   3'd4, 1));

    // LDUSE_STALL_CYC=3 instance: plain stall, then a stall pre-empted by dmem_busy
    t3.push_back(mk("lu3_a",       3'd0, 0, 3'd3, 1, 3'd3, LD,      STL,   3'd0, 0));
    t3.push_back(mk("lu3_b",       3'd0, 0, 3'd0, 0, 3'd0, C0,      STL,   3'd1, 0));
    t3.push_back(mk("lu3_c",       3'd0, 0, 3'd0, 0, 3'd0, C0,      STL,   3'd1, 0));
    t3.push_back(mk("lu3_release", 3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd1, 0));
    t3.push_back(mk("lu3_run",     3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));
    t3.push_back(mk("lu3p_a",      3'd6, 1, 3'd0, 0, 3'd6, LD,      STL,   3'd0, 0));
    t3.push_back(mk("lu3p_db1",    3'd0, 0, 3'd0, 0, 3'd0, DB,      FRZ,   3'd1, 0));
    t3.push_back(mk("lu3p_db2",    3'd0, 0, 3'd0, 0, 3'd0, DB,      FRZ,   3'd2, 0));
    t3.push_back(mk("lu3p_resume", 3'd0, 0, 3'd0, 0, 3'd0, C0,      STL,   3'd2, 0));
    t3.push_back(mk("lu3p_b",      3'd0, 0, 3'd0, 0, 3'd0, C0,      STL,   3'd1, 0));
    t3.push_back(mk("lu3p_release",3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd1, 0));
    t3.push_back(mk("lu3p_run",    3'd0, 0, 3'd0, 0, 3'd0, C0,      NORM,  3'd0, 0));

    apply(idle);
    rst_n = 1'b0;
    #12;
    check("reset_d1", 0, RSTO, 3'd0, 1'b0);
    check("reset_d3", 1, RSTO, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_table(t1, 0);

`ifdef HAZ_PERF_CNT_EN
    total_cnt++;
    if (flush_cnt1 === 16'd3) pass_cnt++;
    else $display("FAIL flush_cnt     got %0d expected 3", flush_cnt1);
`endif

    // Reset pulse mid-HALT: outputs take reset values at once, history is lost
    apply(idle);
    rst_n = 1'b0;
    #1;
    check("halt_rst_hold", 0, RSTO, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("halt_rst_rel", 0, NORM, 3'd0, 1'b0);
    @(negedge clk);
    check("rst_rel_run3", 1, NORM, 3'd0, 1'b0);

    run_table(t3, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
